// File: rtl/series_sequencer_pkg.sv
// Shared types and widths for the series sequencer: FSM state encoding,
// data/address widths and the term-count clamp.
package series_sequencer_pkg;

  localparam int DATA_W = 17;
  localparam int ADDR_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_MUL_X,
    ST_MUL_I,
    ST_MUL_IP,
    ST_NEG,
    ST_ACC,
    ST_DONE
  } state_e;

  // A requested count of zero still evaluates the initial term.
  function automatic logic [ADDR_W-1:0] clamp_terms(input logic [ADDR_W-1:0] n);
    return (n == '0) ? ADDR_W'(1) : n;
  endfunction

endpackage

// File: rtl/series_sequencer.sv
// Power-series term sequencer: steers an external multiply stage through
// term*x, term*rom[k], term*rom[k+1] (and optional negate), accumulating each term.
module series_sequencer
  import series_sequencer_pkg::*;
#(
  parameter logic signed [DATA_W-1:0] TERM_INIT  = 17'sd1,
  parameter bit                       NEG_SERIES = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic [ADDR_W-1:0]        n_terms,
  input  logic signed [DATA_W-1:0] mult_out,
  output logic                     minus1_en,
  output logic                     x_en,
  output logic                     i_en,
  output logic                     iplus_en,
  output logic signed [DATA_W-1:0] term_out,
  output logic signed [DATA_W-1:0] x_out,
  output logic [ADDR_W-1:0]        rom_addr_i,
  output logic [ADDR_W-1:0]        rom_addr_iplus,
  output logic signed [DATA_W-1:0] result,
  output logic                     busy,
  output logic                     done
);

  state_e                     state_q, state_d;
  logic signed [DATA_W-1:0]   term_q, term_d;
  logic signed [DATA_W-1:0]   sum_q, sum_d;
  logic signed [DATA_W-1:0]   x_q, x_d;
  logic [ADDR_W-1:0]          k_q, k_d;
  logic [ADDR_W-1:0]          n_q, n_d;
  logic                       last_k;

  assign last_k = (ADDR_W'(k_q + 1'b1) == n_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      term_q  <= '0;
      sum_q   <= '0;
      x_q     <= '0;
      k_q     <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      term_q  <= term_d;
      sum_q   <= sum_d;
      x_q     <= x_d;
      k_q     <= k_d;
      n_q     <= n_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_INIT;
      ST_INIT:   state_d = ST_ACC;
      ST_MUL_X:  state_d = ST_MUL_I;
      ST_MUL_I:  state_d = ST_MUL_IP;
      ST_MUL_IP: state_d = NEG_SERIES ? ST_NEG : ST_ACC;
      ST_NEG:    state_d = ST_ACC;
      ST_ACC:    state_d = last_k ? ST_DONE : ST_MUL_X;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    term_d = term_q;
    sum_d  = sum_q;
    x_d    = x_q;
    k_d    = k_q;
    n_d    = n_q;
    case (state_q)
      ST_INIT: begin
        term_d = TERM_INIT;
        sum_d  = '0;
        k_d    = '0;
        x_d    = x_in;
        n_d    = clamp_terms(n_terms);
      end
      ST_MUL_X, ST_MUL_I, ST_MUL_IP, ST_NEG: term_d = mult_out;
      ST_ACC: begin
        sum_d = sum_q + term_q;
        if (!last_k) k_d = k_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    minus1_en      = 1'b0;
    x_en           = 1'b0;
    i_en           = 1'b0;
    iplus_en       = 1'b0;
    busy           = (state_q != ST_IDLE);
    done           = (state_q == ST_DONE);
    rom_addr_i     = k_q;
    // Forced to zero in IDLE so a freshly reset block shows all-zero outputs.
    rom_addr_iplus = (state_q == ST_IDLE) ? '0 : ADDR_W'(k_q + 1'b1);
    case (state_q)
      ST_MUL_X:  x_en      = 1'b1;
      ST_MUL_I:  i_en      = 1'b1;
      ST_MUL_IP: iplus_en  = 1'b1;
      ST_NEG:    minus1_en = 1'b1;
      default: ;
    endcase
  end

  assign term_out = term_q;
  assign x_out    = x_q;
  assign result   = sum_q;

endmodule
